// File: rtl/sd_spi_byte_engine_pkg.sv
// Shared definitions for the SD-card SPI byte engine.
//   spi_state_e : engine state encoding (IDLE=0, SYNC=1, SHIFT=2)
//   MosiIdle    : level driven on MOSI whenever no bit is being presented
package sd_spi_byte_engine_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StSync  = 2'd1,
    StShift = 2'd2
  } spi_state_e;

  localparam logic MosiIdle = 1'b1;

endpackage

// File: rtl/sd_spi_edge_detect.sv
// Rise/fall strobe generator for the divided SPI clock.
//   i_clk   : system clock
//   i_rst_n : synchronous active-low reset
//   i_sclk  : divided SPI clock level, already in the i_clk domain
//   o_rise  : single-cycle strobe, i_sclk went 0->1
//   o_fall  : single-cycle strobe, i_sclk went 1->0
module sd_spi_edge_detect (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sclk,
  output logic o_rise,
  output logic o_fall
);

  logic sclk_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sclk_q <= 1'b0;
    end else begin
      sclk_q <= i_sclk;
    end
  end

  assign o_rise = i_sclk & ~sclk_q;
  assign o_fall = ~i_sclk & sclk_q;

endmodule

// File: rtl/sd_spi_byte_engine.sv
// SPI mode-0 byte shifter for the SD-card path. Gates the divided clock to the
// card only while a byte is in flight, sends one byte MSB-first on MOSI and
// captures one byte from MISO.
//   i_clk, i_rst_n : system clock, synchronous active-low reset
//   i_sclk         : divided SPI clock level (i_clk domain)
//   i_start        : one-cycle transfer request, i_tx_byte sampled with it
//   i_cs_en        : 1 selects the card
//   i_miso         : card data out
//   o_sclk, o_mosi, o_cs_n : card pins (all registered)
//   o_busy, o_done, o_rx_byte : transfer status and received byte
// Optional feature macro: SD_SPI_BURST_EN (accept a start in the o_done cycle
// and continue straight into the next byte without an idle gap).
module sd_spi_byte_engine
  import sd_spi_byte_engine_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_sclk,
  input  logic       i_start,
  input  logic [7:0] i_tx_byte,
  input  logic       i_cs_en,
  input  logic       i_miso,
  output logic       o_sclk,
  output logic       o_mosi,
  output logic       o_cs_n,
  output logic       o_busy,
  output logic       o_done,
  output logic [7:0] o_rx_byte
);

  spi_state_e state_q, state_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] rx_q, rx_d;
  logic [3:0] cnt_q, cnt_d;  // bit 3 is the wrap flag: set after the 8th rise
  logic       sclk_q, sclk_d;
  logic       mosi_q, mosi_d;
  logic       cs_n_q, cs_n_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic       rise, fall;
  logic       start_ok;

  sd_spi_edge_detect u_edge (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_sclk (i_sclk),
    .o_rise (rise),
    .o_fall (fall)
  );

`ifdef SD_SPI_BURST_EN
  assign start_ok = i_start;
`else
  // The o_done cycle is held as an idle gap between bytes.
  assign start_ok = i_start & ~done_q;
`endif

  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    cnt_d     = cnt_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rx_byte_d = rx_byte_q;
    cs_n_d    = ~i_cs_en;

    unique case (state_q)
      StIdle: begin
        // busy stays high through the o_done cycle and drops after it
        busy_d = 1'b0;
        sclk_d = 1'b0;
        if (start_ok) begin
          busy_d  = 1'b1;
          tx_d    = i_tx_byte;
          state_d = StSync;
`ifdef SD_SPI_BURST_EN
          if (done_q) begin
            // The completing fall edge doubles as the sync edge for this byte.
            mosi_d  = i_tx_byte[7];
            tx_d    = {i_tx_byte[6:0], 1'b0};
            cnt_d   = 4'd0;
            state_d = StShift;
          end
`endif
        end
      end
      StSync: begin
        // Presenting bit 7 on a fall gives a half period of setup before the first rise.
        if (fall) begin
          mosi_d  = tx_q[7];
          tx_d    = {tx_q[6:0], 1'b0};
          cnt_d   = 4'd0;
          state_d = StShift;
        end
      end
      StShift: begin
        if (rise) begin
          sclk_d = 1'b1;
          rx_d   = {rx_q[6:0], i_miso};
          cnt_d  = cnt_q + 4'd1;
        end else if (fall) begin
          sclk_d = 1'b0;
          if (!cnt_q[3]) begin
            mosi_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b0};
          end else begin
            mosi_d    = MosiIdle;
            rx_byte_d = rx_q;
            done_d    = 1'b1;
            state_d   = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      tx_q      <= 8'h00;
      rx_q      <= 8'h00;
      cnt_q     <= 4'd0;
      sclk_q    <= 1'b0;
      mosi_q    <= MosiIdle;
      cs_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rx_byte_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      cnt_q     <= cnt_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rx_byte_q <= rx_byte_d;
    end
  end

  assign o_sclk    = sclk_q;
  assign o_mosi    = mosi_q;
  assign o_cs_n    = cs_n_q;
  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_rx_byte = rx_byte_q;

endmodule

// File: tb/tb_sd_spi_byte_engine.sv
// Self-checking bench for sd_spi_byte_engine: table-driven byte transfers with a
// scoreboard checked at o_done, plus hand-written reset, busy-start and
// back-to-back sequences.
module tb_sd_spi_byte_engine;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk_in = 1'b0;
  logic       start = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       cs_en = 1'b0;
  logic [1:0] miso_mode = 2'd0;  // 0: loop MOSI back, 1: const 0, 2: const 1
  wire        miso;
  logic       o_sclk, o_mosi, o_cs_n, o_busy, o_done;
  logic [7:0] o_rx;

  assign miso = (miso_mode == 2'd0) ? o_mosi : (miso_mode == 2'd2);

  sd_spi_byte_engine dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_sclk   (sclk_in),
    .i_start  (start),
    .i_tx_byte(tx_byte),
    .i_cs_en  (cs_en),
    .i_miso   (miso),
    .o_sclk   (o_sclk),
    .o_mosi   (o_mosi),
    .o_cs_n   (o_cs_n),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_rx_byte(o_rx)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int half = 2;
  int hcnt = 0;

  // Behavioural divider: i_sclk toggles every `half` cycles, shortly after posedge.
  always @(posedge clk) begin
    cyc++;
    #1;
    hcnt++;
    if (hcnt >= half) begin
      hcnt = 0;
      sclk_in = ~sclk_in;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    n_vec++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Scoreboard and output monitor (samples on negedge).
  typedef struct {
    logic [7:0] tx;
    logic [7:0] rx;
  } exp_t;
  exp_t sb[$];

  logic       prev_sclk = 1'b0;
  logic       prev_busy = 1'b0;
  logic [7:0] mosi_seen = 8'h00;
  int rise_cnt = 0;
  int total_rises = 0;
  int last_rise = 0;
  bit last_valid = 1'b0;
  int space_err = 0;
  int exp_space = 4;
  int done_cnt = 0;
  int busy_drops = 0;
  bit keep_span = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      rise_cnt   = 0;
      mosi_seen  = 8'h00;
      last_valid = 1'b0;
      space_err  = 0;
      prev_sclk  = 1'b0;
      prev_busy  = 1'b0;
    end else begin
      if (o_sclk && !prev_sclk) begin
        if (last_valid && (cyc - last_rise) != exp_space) space_err++;
        last_rise  = cyc;
        last_valid = 1'b1;
        rise_cnt++;
        total_rises++;
        mosi_seen = {mosi_seen[6:0], o_mosi};
      end
      if (prev_busy && !o_busy) busy_drops++;
      if (o_done) begin
        done_cnt++;
        if (sb.size() == 0) begin
          chk("unexpected o_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("o_rx_byte", o_rx, e.rx);
          chk("mosi bits at rises", mosi_seen, e.tx);
          chk("sclk rises per byte", rise_cnt, 8);
          chk("sclk rise spacing errors", space_err, 0);
        end
        rise_cnt  = 0;
        space_err = 0;
        mosi_seen = 8'h00;
        if (!keep_span) last_valid = 1'b0;
      end
      prev_sclk = o_sclk;
      prev_busy = o_busy;
    end
  end

  // Wait until i_sclk has just risen, so the start lands at a known phase.
  task automatic align();
    int guard = 0;
    do begin
      @(posedge clk);
      #2;
      guard++;
    end while (!(sclk_in === 1'b1 && hcnt == 0) && guard < 1000);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (o_done !== 1'b1 && lat < 5000) begin
      @(posedge clk);
      #2;
      lat++;
    end
    if (o_done !== 1'b1) chk("o_done timeout", 0, 1);
  endtask

  typedef struct {
    logic [7:0] tx;
    logic [1:0] mode;
    int         half;
    logic [7:0] rx;
    int         lo;
    int         hi;
  } vec_t;
  vec_t vecs[6];

  task automatic run_vec(input vec_t v);
    int lat;
    half      = v.half;
    exp_space = 2 * v.half;
    miso_mode = v.mode;
    repeat (4) @(posedge clk);
    align();
    start   = 1'b1;
    tx_byte = v.tx;
    sb.push_back('{tx: v.tx, rx: v.rx});
    @(posedge clk);
    #2;
    start   = 1'b0;
    tx_byte = ~v.tx;  // must not leak into the transfer
    chk("busy after start", o_busy, 1);
    wait_done(lat);
    chk_range("start-to-done latency", lat + 1, v.lo, v.hi);
    chk("busy in done cycle", o_busy, 1);
    @(posedge clk);
    #2;
    chk("busy after done", o_busy, 0);
    chk("done is one pulse", o_done, 0);
    chk("sclk idle low", o_sclk, 0);
    chk("mosi idle high", o_mosi, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int guard;
    int dc;
    vecs[0] = '{tx: 8'hA5, mode: 2'd0, half: 2,   rx: 8'hA5, lo: 34,   hi: 36};
    vecs[1] = '{tx: 8'hFF, mode: 2'd2, half: 2,   rx: 8'hFF, lo: 34,   hi: 36};
    vecs[2] = '{tx: 8'h40, mode: 2'd1, half: 125, rx: 8'h00, lo: 2001, hi: 2251};
    vecs[3] = '{tx: 8'h3C, mode: 2'd0, half: 2,   rx: 8'h3C, lo: 34,   hi: 36};
    vecs[4] = '{tx: 8'h81, mode: 2'd0, half: 3,   rx: 8'h81, lo: 50,   hi: 55};
    vecs[5] = '{tx: 8'h5A, mode: 2'd2, half: 2,   rx: 8'hFF, lo: 34,   hi: 36};

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    chk("reset busy", o_busy, 0);
    chk("reset done", o_done, 0);
    chk("reset sclk", o_sclk, 0);
    chk("reset mosi", o_mosi, 1);
    chk("reset cs_n", o_cs_n, 1);
    chk("reset rx_byte", o_rx, 8'h00);
    rst_n = 1'b1;
    cs_en = 1'b1;
    @(posedge clk);
    #2;
    chk("cs_n follows cs_en=1", o_cs_n, 0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Reset mid-byte after the 3rd rise
    half = 2;
    exp_space = 4;
    miso_mode = 2'd0;
    repeat (4) @(posedge clk);
    align();
    start   = 1'b1;
    tx_byte = 8'hA5;
    sb.push_back('{tx: 8'hA5, rx: 8'hA5});
    @(posedge clk);
    #2;
    start = 1'b0;
    guard = 0;
    while (rise_cnt < 3 && guard < 200) begin
      @(posedge clk);
      #2;
      guard++;
    end
    chk("third rise reached", rise_cnt, 3);
    dc = done_cnt;
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk);
    #2;
    chk("mid reset sclk", o_sclk, 0);
    chk("mid reset mosi", o_mosi, 1);
    chk("mid reset busy", o_busy, 0);
    chk("mid reset done", o_done, 0);
    chk("mid reset cs_n", o_cs_n, 1);
    chk("mid reset rx_byte", o_rx, 8'h00);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    chk("cs_n after reset release", o_cs_n, 0);
    repeat (60) @(posedge clk);
    #2;
    chk("no done after reset", done_cnt, dc);
    chk("idle after reset", o_busy, 0);

    // Start during busy is ignored
    align();
    start   = 1'b1;
    tx_byte = 8'hA5;
    sb.push_back('{tx: 8'hA5, rx: 8'hA5});
    @(posedge clk);
    #2;
    start = 1'b0;
    dc = done_cnt;
    repeat (10) @(posedge clk);
    #2;
    start   = 1'b1;
    tx_byte = 8'h00;
    @(posedge clk);
    #2;
    start = 1'b0;
    wait_done(lat);
    repeat (60) @(posedge clk);
    #2;
    chk("single done for busy start", done_cnt, dc + 1);
    chk("no second transfer", o_busy, 0);

    // Start presented in the o_done cycle
    align();
    start   = 1'b1;
    tx_byte = 8'h12;
    sb.push_back('{tx: 8'h12, rx: 8'h12});
    @(posedge clk);
    #2;
    start = 1'b0;
    dc = done_cnt;
`ifdef SD_SPI_BURST_EN
    keep_span = 1'b1;
    total_rises = 0;
    busy_drops = 0;
`endif
    wait_done(lat);
    start   = 1'b1;
    tx_byte = 8'h34;
`ifdef SD_SPI_BURST_EN
    sb.push_back('{tx: 8'h34, rx: 8'h34});
`endif
    @(posedge clk);
    #2;
    start   = 1'b0;
    tx_byte = 8'h00;
`ifdef SD_SPI_BURST_EN
    chk("busy held into burst", o_busy, 1);
    wait_done(lat);
    chk("burst busy drops", busy_drops, 0);
    chk("burst contiguous rises", total_rises, 16);
    keep_span = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("burst two dones", done_cnt, dc + 2);
`else
    chk("done-cycle start ignored", o_busy, 0);
    repeat (60) @(posedge clk);
    #2;
    chk("no transfer from done-cycle start", done_cnt, dc + 1);
`endif
    chk("scoreboard drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sd_spi_byte_engine.md
# sd_spi_byte_engine

SPI mode-0 byte shifter for the SD-card path. It consumes the divided SPI clock from the SD clock divider (200 kHz init / 12.5 MHz data rate) as a level signal synchronous to `i_clk`. It gates that clock out to the card only while a byte is in flight, shifts one byte out on MOSI MSB-first and captures one byte from MISO. It sits between the SD command/init controller upstream and the card pins downstream.

## Interface
- No parameters.
- `i_clk` in 1: system clock; the same clock that drives the divider.
- `i_rst_n` in 1: synchronous, active-low reset.
- `i_sclk` in 1: divided SPI clock from the divider, registered in the `i_clk` domain.
- `i_start` in 1: one-cycle request to transfer `i_tx_byte`.
- `i_tx_byte` in 8: byte to send; sampled only in the cycle `i_start` is accepted.
- `i_cs_en` in 1: 1 selects the card.
- `i_miso` in 1: card data out.
- `o_sclk` out 1: gated SPI clock to the card.
- `o_mosi` out 1: card data in.
- `o_cs_n` out 1: card chip select, active low.
- `o_busy` out 1: transfer in progress.
- `o_done` out 1: one-cycle pulse when the byte completes.
- `o_rx_byte` out 8: received byte; valid from `o_done` until the next accepted start.

## Operation
- Edge detect:
  - `r_sclk_d` is `i_sclk` delayed by one cycle.
  - rise = `i_sclk & ~r_sclk_d`; fall = `~i_sclk & r_sclk_d`.
  - Each edge is a single-cycle strobe.
- States:
  - IDLE: `o_busy`=0, `o_sclk`=0, `o_mosi`=1. `i_start` is accepted, the byte is latched, and the state goes to SYNC.
  - SYNC: wait for a fall strobe. On it, drive `o_mosi`=bit7, clear the bit counter, and go to SHIFT. This guarantees MOSI setup of a full half-period before the first rising edge.
  - SHIFT, on rise: `o_sclk`←1, `r_rx`←{`r_rx[6:0]`, `i_miso`}, and the counter increments (3-bit plus wrap flag).
  - SHIFT, on fall: `o_sclk`←0.
    - If fewer than 8 bits have been sampled, `o_mosi`←next bit.
    - Otherwise `o_mosi`←1, `o_rx_byte`←`r_rx`, `o_done`=1, and the state goes to IDLE.
- Exactly 8 rising edges appear on `o_sclk` per byte. `o_sclk` ends low (CPOL=0).
- `o_cs_n` is registered as `~i_cs_en` every cycle, independent of the state machine. The controller is responsible for holding it across multi-byte frames.
- `i_start` outside IDLE is ignored: no queueing, no error.
- A change of the divider rate during a transfer is tolerated; edges are simply stretched.
- Reset at any time, including mid-byte, gives next cycle:
  - state IDLE, `o_busy`=0, `o_done`=0
  - `o_sclk`=0, `o_mosi`=1, `o_cs_n`=1
  - `o_rx_byte`=8'h00
  - no partial `o_done`.

## Timing
- `o_busy` is high from the cycle after `i_start` is accepted until the cycle after `o_done`.
- All outputs are registered. `o_sclk` lags `i_sclk` by exactly one `i_clk` cycle.
- Latency from accepted start to `o_done` = time to the next `i_sclk` fall, plus 8 full `i_sclk` periods, plus 1 cycle.
  - Fast rate (period 4 cycles): 34–36 cycles.
  - Slow rate (period 250 cycles): about 2001–2251 cycles.
- MISO is sampled in the cycle `o_sclk` is set high. The card changes MISO after a falling edge, so a half-period of margin is guaranteed.

## Configuration
- `SD_SPI_BURST_EN`
  - Defined: an `i_start` in the same cycle as `o_done` is accepted. The engine goes straight to SHIFT with `o_mosi`=new bit7 on that fall edge, so the next byte's first rise follows half a period later with no idle gap. `o_busy` stays high.
  - Undefined: start in the `o_done` cycle is ignored, and at least one IDLE cycle separates bytes.

## Structure
- Shared SD package holds:
  - state encoding (IDLE=2'd0, SYNC=2'd1, SHIFT=2'd2)
  - the MOSI idle level constant (1'b1)
- Natural sub-module: `sd_spi_edge_detect` (`i_clk`, `i_rst_n`, `i_sclk` → rise/fall strobes). Everything else is flat.

## Test plan
- Behavioural `i_sclk` toggles every 2 cycles; `i_miso` is looped from `o_mosi`; start with 8'hA5.
  - Expect MOSI bits 1,0,1,0,0,1,0,1 at successive `o_sclk` rises.
  - Expect exactly 8 rises, then `o_done` with `o_rx_byte`=8'hA5 at 34–36 cycles.
- `i_miso`=1 and tx 8'hFF (dummy clocking): expect `o_rx_byte`=8'hFF and `o_mosi` high throughout.
- `i_sclk` toggles every 125 cycles, tx 8'h40 with `i_miso`=0: expect `o_rx_byte`=8'h00, `o_done` after about 2000+ cycles, and 8 `o_sclk` rises at 250-cycle spacing.
- Assert `i_rst_n`=0 after the 3rd rise: expect `o_sclk`=0, `o_mosi`=1, `o_busy`=0, and no `o_done` in the next cycle.
- Pulse `i_start` with 8'h00 during busy: expect the original byte to complete unchanged and no second transfer.
- Under `SD_SPI_BURST_EN`: start 8'h12, then 8'h34 in the `o_done` cycle.
  - Expect 16 contiguous `o_sclk` rises.
  - Expect looped-back `o_rx_byte` 8'h12 then 8'h34.
  - Expect `o_busy` never to drop between the bytes.
